// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
package mdu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = XLEN + 1;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // True for the two divide-class operations
    function automatic logic is_div(input op_e o);
        return (o == OP_DIVU) || (o == OP_REMU);
    endfunction

    // Picks the architectural result out of the final accumulator
    function automatic logic [XLEN-1:0] select_result(input op_e o, input logic [2*XLEN-1:0] a);
        case (o)
            OP_MUL:   return a[XLEN-1:0];
            OP_MULHU: return a[2*XLEN-1:XLEN];
            OP_DIVU:  return a[XLEN-1:0];
            default:  return a[2*XLEN-1:XLEN];
        endcase
    endfunction

endpackage

// File: rtl/mdu_addsub.sv
// 33-bit adder/subtractor shared by the multiply and divide steps.
module mdu_addsub
    import mdu_pkg::*;
(
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    input  logic          sub,
    output logic [AW-1:0] sum,
    output logic          cout
);

    // a + b, or a - b as a + ~b + 1; cout=1 on subtract means a >= b
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, (sub ? ~b : b)} + (AW+1)'(sub);
    end

endmodule

// File: rtl/mdu_seq.sv
// Radix-2 iterative MUL/MULHU/DIVU/REMU unit with pipeline stall/flush hooks.
module mdu_seq
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_e              state;
    op_e                 op_q;
    logic [CNT_W-1:0]    cnt;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     opnd2;

    logic [AW-1:0]       as_a;
    logic [AW-1:0]       as_b;
    logic [AW-1:0]       as_sum;
    logic                as_cout;
    logic                as_sub;
    logic [AW-1:0]       mul_hi;
    logic [2*XLEN-1:0]   acc_next;
    op_e                 op_in;

    assign op_in = op_e'(op);

    mdu_addsub u_addsub (
        .a    (as_a),
        .b    (as_b),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (as_cout)
    );

    // One shift-add (multiply) or restoring-subtract (divide) step
    always_comb begin
        as_sub   = is_div(op_q);
        as_b     = {1'b0, opnd2};
        as_a     = {1'b0, acc[2*XLEN-1:XLEN]};
        mul_hi   = acc[0] ? as_sum : {1'b0, acc[2*XLEN-1:XLEN]};
        acc_next = {mul_hi, acc[XLEN-1:1]};
        if (as_sub) begin
            as_a     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
            acc_next = {(as_cout ? as_sum[XLEN-1:0] : as_a[XLEN-1:0]), acc[XLEN-2:0], as_cout};
        end
    end

    // Pipeline hold: request being accepted this cycle, or iteration running
    always_comb begin
        stall = rst_n && (((state == ST_IDLE) && start && !flush) || (state == ST_CALC));
    end

    // Control FSM, iteration datapath and registered result/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_q   <= OP_MUL;
            cnt    <= '0;
            acc    <= '0;
            opnd2  <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        op_q  <= op_in;
                        opnd2 <= operand2;
                        cnt   <= '0;
                        if (is_div(op_in) && (operand2 == '0)) begin
                            result <= (op_in == OP_DIVU) ? '1 : operand1;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            acc   <= {XLEN'(0), operand1};
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= CNT_W'(cnt + 1'b1);
                        if (cnt == CNT_W'(XLEN - 1)) begin
                            result <= select_result(op_q, acc_next);
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed scoreboard bench for mdu_seq.
module tb_mdu_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int          checks;
    int          errors;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    mdu_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .operand1 (operand1),
        .operand2 (operand2),
        .flush    (flush),
        .stall    (stall),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation at cycle 0 and wait (bounded) for its done pulse
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        logic seen;
        @(negedge clk);
        start = 1'b1; op = o; operand1 = a; operand2 = b; flush = 1'b0;
        #1 check({tag, " stall_c0"}, 32'(stall), 32'd1);
        exp_q.push_back(exp);
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done) begin
                seen = 1'b1;
                check({tag, " latency"}, 32'(c), 32'(lat));
                check({tag, " result"}, result, exp_q.pop_front());
                check({tag, " stall_done"}, 32'(stall), 32'd0);
                last_res = exp;
            end else if (c == lat - 1) begin
                check({tag, " stall_last_calc"}, 32'(stall), 32'd1);
            end
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        if (!seen && exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    initial begin
        int ndone;
        logic seen;
        checks = 0; errors = 0; last_res = 32'h0;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; operand1 = '0; operand2 = '0; flush = 1'b0;

        // Reset values
        #1;
        check("reset result", result, 32'h0);
        check("reset done", 32'(done), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Multiply and divide patterns
        do_op("mul 7*6",      2'b00, 32'd7, 32'd6, 32'd42, 33);
        do_op("mulhu ff*ff",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("mul ff*ff",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        do_op("divu 100/7",   2'b10, 32'd100, 32'd7, 32'd14, 33);
        do_op("remu 100/7",   2'b11, 32'd100, 32'd7, 32'd2, 33);
        do_op("divu 5/9",     2'b10, 32'd5, 32'd9, 32'd0, 33);
        do_op("divu 123/0",   2'b10, 32'd123, 32'd0, 32'hFFFF_FFFF, 1);
        do_op("remu 123/0",   2'b11, 32'd123, 32'd0, 32'd123, 1);
        do_op("mulhu big",    2'b01, 32'h8000_0001, 32'h0000_0010, 32'h0000_0008, 33);

        // Flush in cycle 10 of a MUL
        @(negedge clk);
        start = 1'b1; op = 2'b00; operand1 = 32'd3; operand2 = 32'd5;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        flush = 1'b1;
        #1 check("flush stall_c10", 32'(stall), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush stall_c11", 32'(stall), 32'd0);
        check("flush result_kept", result, last_res);
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("flush no_done", 32'(ndone), 32'd0);
        do_op("mul after flush", 2'b00, 32'd12, 32'd11, 32'd132, 33);

        // Flush wins over start in IDLE
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; operand1 = 32'd2; operand2 = 32'd2;
        #1 check("flush_vs_start stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1 check("flush_vs_start idle", 32'(stall), 32'd0);

        // Reset in cycle 15 of a DIVU, with start held during reset
        @(negedge clk);
        start = 1'b1; op = 2'b10; operand1 = 32'd1000; operand2 = 32'd3;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1;
        #1;
        check("midreset result", result, 32'h0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        last_res = 32'h0;

        // Start held high (with changing inputs) while busy: exactly one done
        @(negedge clk);
        start = 1'b1; op = 2'b10; operand1 = 32'd200; operand2 = 32'd9;
        exp_q.push_back(32'd22);
        ndone = 0; seen = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c <= 20) begin
                start = 1'b1; op = 2'b00; operand1 = 32'd999; operand2 = 32'd1;
            end else begin
                start = 1'b0;
            end
            #1;
            if (done) begin
                ndone++;
                if (!seen) begin
                    seen = 1'b1;
                    check("busy latency", 32'(c), 32'd33);
                    check("busy result", result, exp_q.pop_front());
                end
            end
        end
        check("busy one_done", 32'(ndone), 32'd1);
        if (!seen && exp_q.size() > 0) void'(exp_q.pop_front());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: EX stage holds a mul/div instruction; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2 bits: 00 MUL (low 32), 01 MULHU (high 32, unsigned), 10 DIVU, 11 REMU.
REQ-005 SHALL have port operand1, input, 32 bits: multiplicand or dividend, captured with start.
REQ-006 SHALL have port operand2, input, 32 bits: multiplier or divisor, captured with start.
REQ-007 SHALL have port flush, input, 1 bit: abort the current operation (branch/jal taken).
REQ-008 SHALL have port stall, output, 1 bit: freezes IF/ID/EX while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse; result is valid in the same cycle.
REQ-010 SHALL have port result, output, 32 bits: registered result; holds its value until the next done.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and DONE.
REQ-012 SHALL, in IDLE with start=1 and flush=0, capture op and operands, clear the 5-bit counter and go to CALC.
REQ-013 SHALL, in CALC, perform one radix-2 step per cycle for exactly 32 cycles (counter 0..31), then go to DONE.
REQ-014 SHALL compute MUL/MULHU by unsigned shift-add into a 64-bit product and DIVU/REMU by restoring division on a 33-bit partial remainder.
REQ-015 SHALL take DONE -> IDLE unconditionally; done=1 only in DONE.
REQ-016 SHALL drive stall = (IDLE and start and not flush) or CALC, combinationally; stall=0 in DONE so the pipeline advances on the done cycle.
REQ-017 SHALL give latency: start sampled at edge 0; CALC in cycles 1..32; done in cycle 33; stall high in cycles 0..32.
REQ-018 SHALL, when DIVU/REMU is started with operand2=0, skip CALC (IDLE -> DONE, done in cycle 1) with result 0xFFFFFFFF for DIVU and operand1 for REMU.
REQ-019 SHALL ignore start outside IDLE; captured operands are not disturbed by input changes during CALC.
REQ-020 SHALL, on flush=1 in CALC or DONE, go to IDLE on the next edge with done=0 and result unchanged; stall drops in the cycle after flush.
REQ-021 SHALL let flush win over start when both are 1 in IDLE: no capture and stall=0.
REQ-022 SHALL update result only on entry to DONE; all 32-bit arithmetic wraps modulo 2^32.

Reset
REQ-023 SHALL, on rst_n=0 at any time including mid-CALC, immediately force state IDLE, counter 0, result 0x00000000, done 0 and stall 0 (start ignored while rst_n=0).
REQ-024 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Structure
REQ-025 SHALL keep the op encodings and FSM state encodings in the shared package, mdu_pkg, for use by decode and hazard logic.
REQ-026 SHALL implement the shared 33-bit adder/subtractor, used by both multiply and divide steps, in one sub-module, mdu_addsub.
REQ-027 SHALL use a single shift register (64-bit accumulator/quotient) and a 5-bit counter; total RTL size is 120-400 lines.

Verification
REQ-028 SHALL cover: MUL 7*6 -> result 42, done in cycle 33, stall high in cycles 0..32.
REQ-029 SHALL cover: MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MUL of the same operands -> 0x00000001.
REQ-030 SHALL cover: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/9 -> 0.
REQ-031 SHALL cover: DIVU 123/0 -> 0xFFFFFFFF and REMU 123/0 -> 123, each with done in cycle 1.
REQ-032 SHALL cover: flush in cycle 10 of a MUL -> no done, result keeps its previous value, IDLE in cycle 11; a following start works normally.
REQ-033 SHALL cover: rst_n low in cycle 15 of a DIVU -> outputs 0 immediately; a start asserted while busy is ignored, so exactly one done is produced.
